// File: rtl/fpu_arbiter.sv
// fpu_arbiter: two requesters share one pipelined fpu.
//
// Purpose
//   Round-robin arbitration between two request ports in front of a single
//   fpu with a fixed result latency. One operation can be issued per cycle.
//   A small tag pipeline remembers which port issued each in-flight
//   operation, so that the result is strobed back to the right requester.
//
// Parameters
//   LATENCY  edges from the fpu sampling its operands to fpu_ans being valid
//            (1..8, default 4)
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready       request handshake for port N (ready is combinational)
//   reqN_op/rmode/opa/opb         request fields for port N
//   fpu_op/rmode/opa/opb          registered operands driving the shared fpu
//   fpu_ans, fpu_flags            fpu result and {inf,snan,qnan,ine,ovf,unf,zero,dbz}
//   rsp0_valid, rsp1_valid        one-cycle result strobe per requester
//   rsp_data, rsp_flags           registered fpu result, shared by both ports
//   busy                          an accepted operation has not finished its strobe
//
// Configuration
//   FPU_ARBITER_STATS_EN  when defined, adds grant0_count / grant1_count
//                         (16-bit wrapping handshake counters per port).

module fpu_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [1:0]  req0_rmode,
  input  logic [31:0] req0_opa,
  input  logic [31:0] req0_opb,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [1:0]  req1_rmode,
  input  logic [31:0] req1_opa,
  input  logic [31:0] req1_opb,
  output logic [2:0]  fpu_op,
  output logic [1:0]  fpu_rmode,
  output logic [31:0] fpu_opa,
  output logic [31:0] fpu_opb,
  input  logic [31:0] fpu_ans,
  input  logic [7:0]  fpu_flags,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_flags,
  output logic        busy
`ifdef FPU_ARBITER_STATS_EN
  ,
  output logic [15:0] grant0_count,
  output logic [15:0] grant1_count
`endif
);

  // Round-robin pointer: the port that wins when both are valid.
  logic prio_ptr;

  logic hs_any;  // a handshake happens at the coming edge
  logic hs_id;   // port id of that handshake

  // Tag pipeline: stage k holds the operation issued k+1 edges ago.
  logic [LATENCY:0] tag_valid;
  logic [LATENCY:0] tag_id;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        req0_ready = ~prio_ptr;
        req1_ready = prio_ptr;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  // Ready is only ever raised on a valid port, so ready alone marks a handshake.
  assign hs_any = req0_ready | req1_ready;
  assign hs_id  = req1_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      prio_ptr   <= 1'b0;
      tag_valid  <= '0;
      tag_id     <= '0;
      fpu_op     <= '0;
      fpu_rmode  <= '0;
      fpu_opa    <= '0;
      fpu_opb    <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
    end else begin
      tag_valid <= {tag_valid[LATENCY-1:0], hs_any};
      tag_id    <= {tag_id[LATENCY-1:0], hs_id};

      // The last tag stage lines up with fpu_ans; the strobe is registered
      // together with the result so both appear in the same cycle.
      rsp0_valid <= tag_valid[LATENCY] & ~tag_id[LATENCY];
      rsp1_valid <= tag_valid[LATENCY] &  tag_id[LATENCY];
      rsp_data   <= fpu_ans;
      rsp_flags  <= fpu_flags;

      if (hs_any) begin
        prio_ptr  <= ~hs_id;  // the other port wins the next tie
        fpu_op    <= hs_id ? req1_op    : req0_op;
        fpu_rmode <= hs_id ? req1_rmode : req0_rmode;
        fpu_opa   <= hs_id ? req1_opa   : req0_opa;
        fpu_opb   <= hs_id ? req1_opb   : req0_opb;
      end
    end
  end

  // The strobe cycle itself still counts as busy: an operation is finished
  // only once its response has been presented.
  assign busy = (|tag_valid) | rsp0_valid | rsp1_valid;

`ifdef FPU_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_count <= '0;
      grant1_count <= '0;
    end else begin
      if (req0_ready) grant0_count <= grant0_count + 16'd1;
      if (req1_ready) grant1_count <= grant1_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter with a stand-in fpu of fixed latency.
// Cycle 0 of each scenario is the first cycle after reset is released;
// inputs change 1 time unit after a rising edge, outputs are sampled on the
// falling edge of the same cycle.

module tb_fpu_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [2:0]  req0_op;
  logic [1:0]  req0_rmode;
  logic [31:0] req0_opa, req0_opb;
  logic        req1_valid, req1_ready;
  logic [2:0]  req1_op;
  logic [1:0]  req1_rmode;
  logic [31:0] req1_opa, req1_opb;
  logic [2:0]  fpu_op;
  logic [1:0]  fpu_rmode;
  logic [31:0] fpu_opa, fpu_opb, fpu_ans;
  logic [7:0]  fpu_flags;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic        busy;
`ifdef FPU_ARBITER_STATS_EN
  logic [15:0] grant0_count, grant1_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_rmode(req0_rmode), .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_rmode(req1_rmode), .req1_opa(req1_opa), .req1_opb(req1_opb),
    .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_ans(fpu_ans), .fpu_flags(fpu_flags),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
`ifdef FPU_ARBITER_STATS_EN
    .grant0_count(grant0_count), .grant1_count(grant1_count),
`endif
    .busy(busy)
  );

  // Stand-in fpu: integer sum of the operands, except the one directed
  // single-precision case 1.0 + 2.0 = 3.0; div (op 3) by zero raises div_by_zero.
  function automatic logic [31:0] model_ans(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  function automatic logic [7:0] model_flags(logic [2:0] op, logic [31:0] b);
    return (op == 3'd3 && b == 32'd0) ? 8'h01 : 8'h00;
  endfunction

  logic [31:0] m_ans   [LAT];
  logic [7:0]  m_flags [LAT];

  always @(posedge clk) begin
    m_ans[0]   <= model_ans(fpu_op, fpu_opa, fpu_opb);
    m_flags[0] <= model_flags(fpu_op, fpu_opb);
    for (int i = 1; i < LAT; i++) begin
      m_ans[i]   <= m_ans[i-1];
      m_flags[i] <= m_flags[i-1];
    end
  end

  assign fpu_ans   = m_ans[LAT-1];
  assign fpu_flags = m_flags[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = '0; req0_rmode = '0; req0_opa = '0; req0_opb = '0;
    req1_valid = 1'b0; req1_op = '0; req1_rmode = '0; req1_opa = '0; req1_opb = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] n0, n1;
    logic [4:0]  exp_grant;
    logic [4:0]  exp_ptr;

    // Reset state, including ready held low while rst is high.
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("rst req0_ready", req0_ready, 0);
    check("rst req1_ready", req1_ready, 0);
    check("rst fpu_opa", fpu_opa, 0);
    check("rst fpu_op", {fpu_rmode, fpu_op}, 0);
    check("rst rsp valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst rsp_data", rsp_data, 0);
    check("rst rsp_flags", rsp_flags, 0);
    check("rst busy", busy, 0);
    check("rst ptr", dut.prio_ptr, 0);

    // Single port-0 add: 1.0 + 2.0 strobed on rsp0 in cycle 6 only.
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd0; req0_opa = 32'h3F80_0000; req0_opb = 32'h4000_0000;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 0) check("s1 req0_ready", req0_ready, 1);
      if (c == 1 || c == 3) begin
        check($sformatf("s1 fpu_opa c%0d", c), fpu_opa, 32'h3F80_0000);
        check($sformatf("s1 fpu_opb c%0d", c), fpu_opb, 32'h4000_0000);
      end
      check($sformatf("s1 rsp0_valid c%0d", c), rsp0_valid, (c == 6));
      check($sformatf("s1 rsp1_valid c%0d", c), rsp1_valid, 0);
      check($sformatf("s1 busy c%0d", c), busy, (c >= 1 && c <= 6));
      if (c == 6) begin
        check("s1 rsp_data", rsp_data, 32'h4040_0000);
        check("s1 rsp_flags", rsp_flags, 0);
      end
      next_cycle();
      req0_valid = 1'b0;
    end

    // Both ports valid for 6 cycles: alternating grants and strobes.
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int c = 0; c <= 12; c++) begin
      req0_valid = (c < 6); req0_op = 3'd1; req0_opa = 32'h100 + n0; req0_opb = 32'd1;
      req1_valid = (c < 6); req1_op = 3'd1; req1_opa = 32'h200 + n1; req1_opb = 32'd1;
      @(negedge clk);
      if (c < 6) begin
        check($sformatf("s2 req0_ready c%0d", c), req0_ready, (c % 2 == 0));
        check($sformatf("s2 req1_ready c%0d", c), req1_ready, (c % 2 == 1));
      end
      check($sformatf("s2 busy c%0d", c), busy, (c >= 1 && c <= 11));
      if (c >= 6 && c <= 11) begin
        check($sformatf("s2 rsp0_valid c%0d", c), rsp0_valid, ((c - 6) % 2 == 0));
        check($sformatf("s2 rsp1_valid c%0d", c), rsp1_valid, ((c - 6) % 2 == 1));
        check($sformatf("s2 rsp_data c%0d", c), rsp_data,
              (((c - 6) % 2 == 1) ? 32'h200 : 32'h100) + (c - 6) / 2 + 1);
      end else begin
        check($sformatf("s2 no strobe c%0d", c), {rsp0_valid, rsp1_valid}, 0);
      end
      if (c < 6) begin
        if (c % 2 == 0) n0++;
        else n1++;
      end
      next_cycle();
    end

    // Port 1 alone for 3 cycles, then both: grants 1,1,1,0,1.
    do_reset();
    exp_grant = 5'b10111;  // bit c = granted port in cycle c
    exp_ptr   = 5'b01000;  // bit c = pointer after the edge ending cycle c
    for (int c = 0; c <= 4; c++) begin
      req0_valid = (c >= 3);
      req1_valid = 1'b1;
      @(negedge clk);
      check($sformatf("s3 req1_ready c%0d", c), req1_ready, exp_grant[c]);
      check($sformatf("s3 req0_ready c%0d", c), req0_ready, !exp_grant[c]);
      next_cycle();
      check($sformatf("s3 ptr after c%0d", c), dut.prio_ptr, exp_ptr[c]);
    end
    idle_inputs();

    // Reset mid-operation discards everything in flight.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      req0_valid = (c <= 3); req0_op = 3'd1; req0_opa = 32'h40 + c; req0_opb = 32'd2;
      rst = (c == 3);
      @(negedge clk);
      if (c == 3) check("s4 ready during rst", req0_ready, 0);
      if (c >= 4) begin
        check($sformatf("s4 no strobe c%0d", c), {rsp0_valid, rsp1_valid}, 0);
        check($sformatf("s4 busy c%0d", c), busy, 0);
      end
      if (c == 4) check("s4 ptr", dut.prio_ptr, 0);
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();

    // Port-1 divide by zero: flags reach rsp_flags with rsp1_valid.
    do_reset();
    req1_valid = 1'b1; req1_op = 3'd3; req1_opa = 32'h4000_0000; req1_opb = 32'd0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 0) check("s5 req1_ready", req1_ready, 1);
      check($sformatf("s5 rsp1_valid c%0d", c), rsp1_valid, (c == 6));
      check($sformatf("s5 rsp0_valid c%0d", c), rsp0_valid, 0);
      if (c == 6) begin
        check("s5 rsp_flags", rsp_flags, 8'h01);
        check("s5 rsp_data", rsp_data, 32'h4000_0000);
      end
      next_cycle();
      req1_valid = 1'b0;
    end

`ifdef FPU_ARBITER_STATS_EN
    // 65537 port-0 handshakes wrap the 16-bit counter to 1.
    do_reset();
    check("s6 grant0 reset", grant0_count, 0);
    req0_valid = 1'b1;
    repeat (65537) next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("s6 grant0_count", grant0_count, 16'h0001);
    check("s6 grant1_count", grant1_count, 16'h0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
